// File: rtl/adc_pkg.sv
// Shared parameters, FSM encoding and round-robin helper for the ADC reader.
package adc_pkg;
  localparam int ADC_NCH = 8;
  localparam int ADC_DW  = 10;
  localparam int ADC_CW  = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // Index following idx in a ring of n entries (n-1 wraps to 0).
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/adc_reader_rr_arbiter.sv
// Combinational round-robin picker: search starts one past ptr and wraps.
module rr_arbiter
  import adc_pkg::*;
#(
  parameter int NCH = ADC_NCH,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic           gnt_any,
  output logic [CW-1:0]  gnt_idx
);
  logic [CW-1:0]    start;
  logic [CW-1:0]    off;
  logic [CW:0]      sum;
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;

  // Rotate so the start position sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    start   = CW'(rr_next(int'(ptr), NCH));
    dbl     = {req, req} >> start;
    rot     = dbl[NCH-1:0];
    gnt_any = |rot;
    off     = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (rot[k]) off = CW'(k);
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (CW+1)'(NCH)) sum = sum - (CW+1)'(NCH);
    gnt_idx = sum[CW-1:0];
  end
endmodule

// File: rtl/adc_reader.sv
// Snapshots completed SAR channel samples and streams {chan, data} round-robin
// over valid/ready. Outputs are fully registered; bank_in only reaches them via snapshots.
module adc_reader
  import adc_pkg::*;
#(
  parameter int NCH = ADC_NCH,
  parameter int DW  = ADC_DW,
  parameter int CW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*DW-1:0] bank_in,
  input  logic [NCH-1:0]    conv_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CW-1:0]     m_chan,
  output logic [DW-1:0]     m_data,
  output logic [NCH-1:0]    overrun,
  input  logic              clr_overrun
);
  state_t                 state_q, state_d;
  logic [NCH-1:0][DW-1:0] snap_q;
  logic [NCH-1:0][DW-1:0] bank;
  logic [NCH-1:0]         pending_q;
  logic [NCH-1:0]         gnt_oh;
  logic [CW-1:0]          ptr_q;
  logic [CW-1:0]          gnt_idx;
  logic                   gnt_any;
  logic                   gnt;

  assign bank    = bank_in;
  assign m_valid = (state_q == S_SEND);

  rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .req     (pending_q),
    .ptr     (ptr_q),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  // Next state and grant: grant when the output register is free or being drained this cycle.
  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    case (state_q)
      S_IDLE: if (gnt_any) begin
        gnt     = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: if (m_ready) begin
        if (gnt_any) gnt = 1'b1;
        else         state_d = S_IDLE;
      end
    endcase
  end

  // One-hot of the channel being granted this cycle.
  always_comb gnt_oh = gnt ? (NCH'(1) << gnt_idx) : '0;

  // State, rr pointer and output word register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= CW'(NCH - 1);
      m_chan  <= '0;
      m_data  <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        ptr_q  <= gnt_idx;
        m_chan <= gnt_idx;
        m_data <= snap_q[gnt_idx];  // pre-edge snapshot: a same-cycle capture goes out next
      end
    end
  end

  // Per-channel capture, pending and sticky overrun (a new overrun beats the clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q    <= '0;
      pending_q <= '0;
      overrun   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (conv_done[i]) snap_q[i] <= bank[i];
        pending_q[i] <= conv_done[i] | (pending_q[i] & ~gnt_oh[i]);
        if (conv_done[i] && pending_q[i] && !gnt_oh[i]) overrun[i] <= 1'b1;
        else if (clr_overrun)                           overrun[i] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_reader.sv
// Self-checking bench for adc_reader: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_adc_reader;
  localparam int NCH = 8;
  localparam int DW  = 10;
  localparam int CW  = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NCH-1:0][DW-1:0] bank_arr;
  logic [NCH*DW-1:0]      bank_in;
  logic [NCH-1:0]         conv_done;
  logic                   m_valid, m_ready, clr_overrun;
  logic [CW-1:0]          m_chan;
  logic [DW-1:0]          m_data;
  logic [NCH-1:0]         overrun;

  int errs   = 0;
  int checks = 0;

  // reference model state
  logic [NCH-1:0]         mp;
  logic [NCH-1:0][DW-1:0] ms;
  logic [NCH-1:0]         movr;
  int                     mptr;
  logic                   mv;
  logic [CW-1:0]          mch;
  logic [DW-1:0]          md;

  assign bank_in = bank_arr;
  always #5 clk = ~clk;

  adc_reader dut (
    .clk         (clk),
    .reset       (reset),
    .bank_in     (bank_in),
    .conv_done   (conv_done),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_chan      (m_chan),
    .m_data      (m_data),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mp = '0; ms = '0; movr = '0; mptr = NCH - 1; mv = 1'b0; mch = '0; md = '0;
  endtask

  // One clock edge of the spec's behaviour: free output slot -> pick next pending
  // after the last winner; then captures land, overrunning anything still queued.
  task automatic model_edge();
    logic          fire, may, found;
    logic [CW-1:0] g, c;
    fire  = mv && m_ready;
    may   = !mv || fire;
    found = 1'b0;
    g     = '0;
    if (may)
      for (int k = 1; k <= NCH; k++) begin
        c = CW'((mptr + k) % NCH);
        if (!found && mp[c]) begin found = 1'b1; g = c; end
      end
    if (found) begin
      mch = g; md = ms[g]; mp[g] = 1'b0; mptr = int'(g); mv = 1'b1;
    end else if (fire) mv = 1'b0;
    if (clr_overrun) movr = '0;
    for (int i = 0; i < NCH; i++)
      if (conv_done[i]) begin
        if (mp[i]) movr[i] = 1'b1;
        ms[i] = bank_arr[i];
        mp[i] = 1'b1;
      end
  endtask

  task automatic compare();
    chk("m_valid", 32'(m_valid), 32'(mv));
    if (mv) begin
      chk("m_chan", 32'(m_chan), 32'(mch));
      chk("m_data", 32'(m_data), 32'(md));
    end
    chk("overrun", 32'(overrun), 32'(movr));
  endtask

  // One cycle: inputs already stable, edge, model step, sample on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    conv_done   = '0;
    clr_overrun = 1'b0;
  endtask

  task automatic cap(input logic [CW-1:0] ch, input logic [DW-1:0] v);
    bank_arr[ch]  = v;
    conv_done[ch] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; conv_done = '0; m_ready = 1'b0; clr_overrun = 1'b0; bank_arr = '0;
    repeat (2) @(negedge clk);
    model_reset();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_chan",  32'(m_chan),  32'd0);
    chk("rst_data",  32'(m_data),  32'd0);
    chk("rst_ovr",   32'(overrun), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    // 1: single sample, two edges to valid
    do_reset();
    m_ready = 1'b1;
    cap(3'd1, 10'h32B);
    cyc();
    chk("t1_not_yet", 32'(m_valid), 32'd0);
    cyc();
    chk("t1_valid", 32'(m_valid), 32'd1);
    chk("t1_chan",  32'(m_chan),  32'd1);
    chk("t1_data",  32'(m_data),  32'h32B);
    cyc();
    chk("t1_done", 32'(m_valid), 32'd0);

    // 2: backpressure holds the word
    do_reset();
    cap(3'd4, 10'h303);
    cyc(); cyc();
    repeat (5) begin
      cyc();
      chk("t2_hold_chan", 32'(m_chan), 32'd4);
      chk("t2_hold_data", 32'(m_data), 32'h303);
    end
    m_ready = 1'b1;
    cyc();
    chk("t2_one_beat", 32'(m_valid), 32'd0);

    // 3: simultaneous captures served round-robin from ptr=7
    do_reset();
    m_ready = 1'b1;
    cap(3'd1, 10'h011); cap(3'd4, 10'h044); cap(3'd7, 10'h077);
    cyc();
    cyc(); chk("t3_first",  32'(m_chan), 32'd1);
    cyc(); chk("t3_second", 32'(m_chan), 32'd4);
    cyc(); chk("t3_third",  32'(m_chan), 32'd7);
    cyc(); chk("t3_idle",   32'(m_valid), 32'd0);

    // 4: overrun keeps only the newest sample
    do_reset();
    cap(3'd0, 10'h0AA);
    cyc(); cyc();
    cap(3'd2, 10'h001); cyc();
    cap(3'd2, 10'h3FF); cyc();
    chk("t4_overrun", 32'(overrun), 32'h04);
    m_ready = 1'b1;
    cyc();
    chk("t4_chan", 32'(m_chan), 32'd2);
    chk("t4_data", 32'(m_data), 32'h3FF);
    cyc();
    chk("t4_single", 32'(m_valid), 32'd0);
    clr_overrun = 1'b1;
    cyc();
    chk("t4_clear", 32'(overrun), 32'h00);

    // 5: grant and capture on the same channel in one cycle
    do_reset();
    cap(3'd3, 10'h111); cyc();
    cap(3'd3, 10'h222); cyc();
    chk("t5_old",  32'(m_data), 32'h111);
    chk("t5_novr", 32'(overrun), 32'h00);
    m_ready = 1'b1;
    cyc();
    chk("t5_new_valid", 32'(m_valid), 32'd1);
    chk("t5_new", 32'(m_data), 32'h222);
    cyc();
    chk("t5_end", 32'(m_valid), 32'd0);

    // 6: async reset mid-stream drops the queue
    do_reset();
    cap(3'd0, 10'h100); cap(3'd1, 10'h101); cap(3'd2, 10'h102); cap(3'd3, 10'h103);
    cyc(); cyc();
    chk("t6_busy", 32'(m_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid0", 32'(m_valid), 32'd0);
    chk("t6_chan0",  32'(m_chan),  32'd0);
    chk("t6_data0",  32'(m_data),  32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    m_ready = 1'b1;
    repeat (5) cyc();
    cap(3'd5, 10'h255);
    cyc(); cyc();
    chk("t6_alive", 32'(m_chan), 32'd5);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NCH; i++) bank_arr[i] = DW'($urandom);
      conv_done   = NCH'($urandom & $urandom & $urandom);
      m_ready     = ($urandom_range(0, 9) < 7);
      clr_overrun = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
